// File: rtl/keccak_digest_tx.sv
// keccak_digest_tx
//
// Takes the 1600-bit Keccak state after the final permutation and streams the
// first DIGEST_BYTES digest bytes in FIPS 202 squeeze order over a valid/ready
// byte handshake. Byte k comes from lane k/8 (lanes ordered (0,0),(1,0),...)
// and is little-endian within that lane.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   load       one-cycle capture request, honoured only in IDLE
//   state      1600-bit Keccak state, lane (x,y) at [1599-64*(5y+x) -: 64]
//   busy       high while streaming
//   out_data   current output byte
//   out_valid  out_data is valid
//   out_ready  consumer accepts the byte on out_valid && out_ready
//   done       one-cycle pulse after the final byte is accepted
//
// Optional feature: define KECCAK_DIGEST_HEX_EN to emit every digest byte as
// two lowercase ASCII hex characters, high nibble first.

module keccak_digest_tx #(
    parameter int DIGEST_BYTES = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [1599:0] state,
    output logic          busy,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          done
);

    localparam int SW = 8 * DIGEST_BYTES;
    localparam int CW = $clog2(DIGEST_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGEST_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [SW-1:0] sreg_q, sreg_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] capture;
    logic          byteAccepted;
    logic          unusedStateBits;

    // Only the first few lanes feed the digest; the remainder is folded here
    // so the unused part of the state bus is visibly intentional.
    assign unusedStateBits = ^state;

    // Reorder the digest bytes so byte k sits at sreg[8k+7:8k]; shifting right
    // by 8 then always exposes the next byte in the low position.
    for (genvar k = 0; k < DIGEST_BYTES; k++) begin : g_capture
        assign capture[8*k +: 8] = state[1536 - 64*(k/8) + 8*(k%8) +: 8];
    end

`ifdef KECCAK_DIGEST_HEX_EN
    logic       nibble_q, nibble_d;
    logic [3:0] curNibble;

    // nibble_q=0 while the high-nibble character is offered, 1 for the low one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nibble_q <= 1'b0;
        end else begin
            nibble_q <= nibble_d;
        end
    end

    always_comb begin
        nibble_d     = nibble_q;
        byteAccepted = 1'b0;
        curNibble    = nibble_q ? sreg_q[3:0] : sreg_q[7:4];
        if (fsm_q == ST_IDLE) begin
            nibble_d = 1'b0;
        end else if (fsm_q == ST_SEND && out_ready) begin
            nibble_d     = ~nibble_q;
            byteAccepted = nibble_q;
        end
    end
`else
    always_comb begin
        byteAccepted = (fsm_q == ST_SEND) && out_ready;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            sreg_q  <= '0;
            count_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            sreg_q  <= sreg_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        sreg_d    = sreg_q;
        count_d   = count_q;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        done      = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (load) begin
                    sreg_d  = capture;
                    count_d = '0;
                    fsm_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef KECCAK_DIGEST_HEX_EN
                out_data  = (curNibble < 4'd10) ? (8'h30 + {4'h0, curNibble})
                                                : (8'h57 + {4'h0, curNibble});
`else
                out_data  = sreg_q[7:0];
`endif
                if (byteAccepted) begin
                    sreg_d  = sreg_q >> 8;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) begin
                        fsm_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done  = 1'b1;
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keccak_digest_tx.sv
// tb_keccak_digest_tx
//
// Scoreboard bench for keccak_digest_tx. Expected bytes are derived from the
// loaded state with an independent lane/byte model and queued when a load is
// driven; a monitor compares every offered byte against the queue head and
// pops on each handshake.

module tb_keccak_digest_tx;

`ifdef KECCAK_DIGEST_HEX_EN
    localparam int DB = 1;
`else
    localparam int DB = 32;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [1599:0] state;
    logic          busy;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          done;

    logic [7:0] expQ[$];
    int vectors = 0;
    int miscompares = 0;
    int xferCount = 0;
    int doneCount = 0;

    keccak_digest_tx #(.DIGEST_BYTES(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .state     (state),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] expByte(input logic [1599:0] s, input int k);
        logic [63:0] lane;
        lane = s[1599 - 64*(k/8) -: 64];
        return lane[8*(k%8) +: 8];
    endfunction

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (out_valid) begin
            checkOutput("sbNonEmpty", (expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                checkOutput("outData", out_data, expQ[0]);
                if (rst_n && out_ready) begin
                    void'(expQ.pop_front());
                    xferCount++;
                end
            end
        end
        if (done) doneCount++;
    end

    task automatic pushExpected(input logic [1599:0] s);
        logic [7:0] b;
        for (int k = 0; k < DB; k++) begin
            b = expByte(s, k);
`ifdef KECCAK_DIGEST_HEX_EN
            expQ.push_back(hexChar(b[7:4]));
            expQ.push_back(hexChar(b[3:0]));
`else
            expQ.push_back(b);
`endif
        end
    endtask

    // Load pulse; the state bus is scrambled to all ones right after the edge
    // so every stream also shows the capture is isolated from the input.
    task automatic applyStimulus(input logic [1599:0] s, input bit expectAccept);
        if (expectAccept) pushExpected(s);
        state = s;
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
        state = '1;
    endtask

    task automatic waitDone(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput(tag, done, 1);
    endtask

    task automatic waitXfers(input string tag, input int target, input int budget);
        int c = 0;
        while (xferCount < target && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput(tag, xferCount, target);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expQ.delete();
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstData", out_data, 0);
        checkOutput("rstDone", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [1599:0] s1, s2, sHex;
        int cycles, base, doneBefore;
        int pattern[4] = '{1, 0, 0, 1};

        rst_n = 1'b0; load = 1'b0; state = '0; out_ready = 1'b0;

        s1 = '0;
        s1[1599 -: 64] = 64'h0706050403020100;
        s1[1535 -: 64] = 64'h0F0E0D0C0B0A0908;
        s2 = '0;
        for (int i = 0; i < 50; i++) s2[32*i +: 32] = $urandom;
        sHex = '0;
        sHex[1599 -: 64] = 64'h00000000000000AB;

        resetDut();

`ifdef KECCAK_DIGEST_HEX_EN
        out_ready = 1'b1;
        checkOutput("hexModelA", expByte(sHex, 0), 8'hAB);
        applyStimulus(sHex, 1);
        waitDone("hexDone", 20, cycles);
        checkOutput("hexLatency", cycles, 2);
        checkOutput("hexXfers", xferCount, 2);
        checkOutput("hexSbEmpty", expQ.size(), 0);
`else
        // Straight stream with out_ready held high.
        out_ready = 1'b1;
        applyStimulus(s1, 1);
        for (int j = 0; j < DB; j++) begin
            checkOutput("streamValid", out_valid, 1);
            checkOutput("streamBusy", busy, 1);
            @(posedge clk); #1;
        end
        checkOutput("doneOnTime", done, 1);
        checkOutput("doneBusy", busy, 0);
        checkOutput("doneValid", out_valid, 0);
        @(posedge clk); #1;
        checkOutput("donePulse", done, 0);
        checkOutput("xfers1", xferCount, DB);
        checkOutput("sbEmpty1", expQ.size(), 0);

        // Backpressure with out_ready pattern 1,0,0,1.
        base = xferCount;
        out_ready = 1'b1;
        applyStimulus(s1, 1);
        cycles = 0;
        while (!done && cycles < 500) begin
            out_ready = pattern[cycles % 4][0];
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("bpDone", done, 1);
        checkOutput("bpXfers", xferCount - base, DB);
        checkOutput("bpSbEmpty", expQ.size(), 0);

        // Second load while busy must be ignored.
        out_ready = 1'b1;
        @(posedge clk); #1;
        base = xferCount;
        applyStimulus(s1, 1);
        waitXfers("busyReach5", base + 5, 100);
        applyStimulus(s2, 0);
        waitDone("busyDone", 200, cycles);
        checkOutput("busyXfers", xferCount - base, DB);
        checkOutput("busySbEmpty", expQ.size(), 0);
        @(posedge clk); #1;
        base = xferCount;
        applyStimulus(s2, 1);
        waitDone("newLoadDone", 200, cycles);
        checkOutput("newLoadXfers", xferCount - base, DB);
        checkOutput("newLoadSbEmpty", expQ.size(), 0);

        // Reset after byte 10 has been accepted.
        @(posedge clk); #1;
        base = xferCount;
        applyStimulus(s2, 1);
        waitXfers("rstReach11", base + 11, 100);
        doneBefore = doneCount;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midRstValid", out_valid, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstData", out_data, 0);
        checkOutput("midRstDone", done, 0);
        rst_n = 1'b1;
        expQ.delete();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("noDoneAfterRst", doneCount, doneBefore);
        base = xferCount;
        applyStimulus(s2, 1);
        waitDone("postRstDone", 200, cycles);
        checkOutput("postRstXfers", xferCount - base, DB);
        checkOutput("postRstSbEmpty", expQ.size(), 0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
